// File: rtl/note_envelope_generator.sv
// note_envelope_generator: per-voice ADSR envelope and note latch feeding the
// tone generator's frequency/amplitude inputs. Runs on the 32 kHz sample clock.
// Optional feature macro: ENVELOPE_EXP_RELEASE_EN selects an exponential
// release (level -= (level>>3)+1) instead of the linear releaseStep.
module note_envelope_generator #(
   parameter int unsigned PRESCALE = 32
) (
   input  logic        CLK_32KHz,
   input  logic        reset_n,
   input  logic        gate,
   input  logic [13:0] inputFrequency,
   input  logic [7:0]  attackStep,
   input  logic [7:0]  decayStep,
   input  logic [7:0]  sustainLevel,
   input  logic [7:0]  releaseStep,
   output logic [13:0] outputFrequency,
   output logic [7:0]  outputAmplitude,
   output logic        active,
   output logic        noteDone
);

   localparam int unsigned PW = 11;
   localparam int unsigned LW = 8;
   localparam int unsigned FW = 14;
   localparam logic [PW-1:0] TICK_CNT = PW'(PRESCALE - 1);
   localparam logic [LW-1:0] LVL_MAX  = {LW{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ATTACK,
      S_DECAY,
      S_SUSTAIN,
      S_RELEASE
   } state_t;

   state_t        r_state;
   logic          r_gate_q;
   logic [PW-1:0] r_presc;
   logic [LW-1:0] r_level;
   logic [FW-1:0] r_freq;
   logic [LW-1:0] r_atk;
   logic [LW-1:0] r_dec;
   logic [LW-1:0] r_sus;
   logic          r_active;
   logic          r_done;

   state_t        w_state_nxt;
   logic [LW-1:0] w_level_nxt;
   logic          w_done_nxt;
   logic          w_start;
   logic          w_tick;
   logic [PW-1:0] w_presc_nxt;
   logic [LW-1:0] w_atk_eff;
   logic [LW-1:0] w_dec_eff;
   logic [LW:0]   w_atk_sum;
   logic [LW-1:0] w_atk_lvl;
   logic [LW:0]   w_dec_floor;
   logic [LW-1:0] w_dec_lvl;
   logic [LW-1:0] w_rel_amt;
   logic [LW-1:0] w_rel_lvl;

`ifdef ENVELOPE_EXP_RELEASE_EN
   logic w_unused_rel;
   assign w_unused_rel = ^releaseStep;

   // Exponential release: step shrinks with the level, always at least 1.
   always_comb begin
      w_rel_amt = (r_level >> 3) + LW'(1);
   end
`else
   logic [LW-1:0] r_rel;

   // Linear release: zero step means an instant drop.
   always_comb begin
      w_rel_amt = (r_rel == '0) ? LVL_MAX : r_rel;
   end
`endif

   // Note start detection and prescaler tick/next count.
   always_comb begin
      w_start = gate & ~r_gate_q;
      w_tick  = (r_presc == TICK_CNT);
      if (w_start || w_tick) begin
         w_presc_nxt = '0;
      end else begin
         w_presc_nxt = r_presc + PW'(1);
      end
   end

   // Candidate levels for each envelope segment, saturated at the bounds.
   always_comb begin
      w_atk_eff   = (r_atk == '0) ? LVL_MAX : r_atk;
      w_dec_eff   = (r_dec == '0) ? LVL_MAX : r_dec;
      w_atk_sum   = {1'b0, r_level} + {1'b0, w_atk_eff};
      w_atk_lvl   = w_atk_sum[LW] ? LVL_MAX : w_atk_sum[LW-1:0];
      w_dec_floor = {1'b0, r_sus} + {1'b0, w_dec_eff};
      if ({1'b0, r_level} > w_dec_floor) begin
         w_dec_lvl = r_level - w_dec_eff;
      end else begin
         w_dec_lvl = r_sus;
      end
      if (r_level > w_rel_amt) begin
         w_rel_lvl = r_level - w_rel_amt;
      end else begin
         w_rel_lvl = '0;
      end
   end

   // Next-state and next-level logic; note start beats gate-low beats tick.
   always_comb begin
      w_state_nxt = r_state;
      w_level_nxt = r_level;
      w_done_nxt  = 1'b0;
      if (w_start) begin
         w_state_nxt = S_ATTACK;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = S_IDLE;
            end
            S_ATTACK: begin
               if (!gate) begin
                  w_state_nxt = S_RELEASE;
               end else if (w_tick) begin
                  w_level_nxt = w_atk_lvl;
                  if (w_atk_lvl == LVL_MAX) begin
                     w_state_nxt = S_DECAY;
                  end
               end
            end
            S_DECAY: begin
               if (!gate) begin
                  w_state_nxt = S_RELEASE;
               end else if (w_tick) begin
                  w_level_nxt = w_dec_lvl;
                  if (w_dec_lvl == r_sus) begin
                     w_state_nxt = S_SUSTAIN;
                  end
               end
            end
            S_SUSTAIN: begin
               if (!gate) begin
                  w_state_nxt = S_RELEASE;
               end else begin
                  w_level_nxt = r_sus;
               end
            end
            S_RELEASE: begin
               if (w_tick) begin
                  w_level_nxt = w_rel_lvl;
                  if (w_rel_lvl == '0) begin
                     w_state_nxt = S_IDLE;
                     w_done_nxt  = 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State, level and status registers.
   always_ff @(posedge CLK_32KHz or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_gate_q <= 1'b0;
         r_presc  <= '0;
         r_level  <= '0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_gate_q <= gate;
         r_presc  <= w_presc_nxt;
         r_level  <= w_level_nxt;
         r_active <= (w_state_nxt != S_IDLE);
         r_done   <= w_done_nxt;
      end
   end

   // Note parameters captured on note start and held until the next one.
   always_ff @(posedge CLK_32KHz or negedge reset_n) begin
      if (!reset_n) begin
         r_freq <= '0;
         r_atk  <= '0;
         r_dec  <= '0;
         r_sus  <= '0;
      end else if (w_start) begin
         r_freq <= inputFrequency;
         r_atk  <= attackStep;
         r_dec  <= decayStep;
         r_sus  <= sustainLevel;
      end
   end

`ifndef ENVELOPE_EXP_RELEASE_EN
   // Release step captured on note start.
   always_ff @(posedge CLK_32KHz or negedge reset_n) begin
      if (!reset_n) begin
         r_rel <= '0;
      end else if (w_start) begin
         r_rel <= releaseStep;
      end
   end
`endif

   assign outputFrequency = r_freq;
   assign outputAmplitude = r_level;
   assign active          = r_active;
   assign noteDone        = r_done;

endmodule

// File: tb/tb_note_envelope_generator.sv
// Testbench for note_envelope_generator: directed ADSR scenarios plus random
// notes, every cycle compared against a behavioural envelope model.
module tb_note_envelope_generator;

   localparam int PRE = 32;
   localparam int PH_IDLE = 0, PH_ATK = 1, PH_DEC = 2, PH_SUS = 3, PH_REL = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        gate;
   logic [13:0] freq_in;
   logic [7:0]  atk, dec, sus, rel;
   logic [13:0] ofreq;
   logic [7:0]  amp;
   logic        act;
   logic        done;

   note_envelope_generator #(.PRESCALE(PRE)) dut (
      .CLK_32KHz      (clk),
      .reset_n        (rst_n),
      .gate           (gate),
      .inputFrequency (freq_in),
      .attackStep     (atk),
      .decayStep      (dec),
      .sustainLevel   (sus),
      .releaseStep    (rel),
      .outputFrequency(ofreq),
      .outputAmplitude(amp),
      .active         (act),
      .noteDone       (done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model state: phase, level, latched note, cycles since last start.
   int m_phase, m_level, m_freq, m_cnt;
   int l_atk, l_dec, l_sus, l_rel;
   bit m_done, m_gprev;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int eff(input int v);
      return (v == 0) ? 255 : v;
   endfunction

   task automatic model_reset();
      m_phase = PH_IDLE; m_level = 0; m_freq = 0; m_cnt = 0;
      m_done = 0; m_gprev = 0;
      l_atk = 0; l_dec = 0; l_sus = 0; l_rel = 0;
   endtask

   // One sample period of the envelope, from the inputs about to be clocked.
   task automatic model_step();
      bit start, tick;
      start   = gate && !m_gprev;
      m_gprev = gate;
      tick    = (m_cnt % PRE) == PRE - 1;
      m_cnt++;
      m_done  = 0;
      if (start) begin
         m_cnt = 0; m_phase = PH_ATK; m_freq = freq_in;
         l_atk = atk; l_dec = dec; l_sus = sus; l_rel = rel;
      end else if ((m_phase == PH_ATK || m_phase == PH_DEC || m_phase == PH_SUS) && !gate) begin
         m_phase = PH_REL;
      end else if (m_phase == PH_SUS) begin
         m_level = l_sus;
      end else if (tick) begin
         case (m_phase)
            PH_ATK: begin
               m_level = m_level + eff(l_atk);
               if (m_level >= 255) begin m_level = 255; m_phase = PH_DEC; end
            end
            PH_DEC: begin
               m_level = m_level - eff(l_dec);
               if (m_level <= l_sus) begin m_level = l_sus; m_phase = PH_SUS; end
            end
            PH_REL: begin
`ifdef ENVELOPE_EXP_RELEASE_EN
               m_level = m_level - (m_level / 8 + 1);
`else
               m_level = m_level - eff(l_rel);
`endif
               if (m_level <= 0) begin m_level = 0; m_phase = PH_IDLE; m_done = 1; end
            end
            default: ;
         endcase
      end
   endtask

   // Advance one clock (starting and ending at a falling edge) and compare.
   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      chk("amp", amp, m_level);
      chk("freq", ofreq, m_freq);
      chk("active", act, m_phase != PH_IDLE);
      chk("done", done, m_done);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      gate  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_amp", amp, 0);
      chk("rst_freq", ofreq, 0);
      chk("rst_active", act, 0);
      chk("rst_done", done, 0);
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic set_note(input int f, input int a, input int d, input int s, input int r);
      freq_in = 14'(f); atk = 8'(a); dec = 8'(d); sus = 8'(s); rel = 8'(r);
   endtask

   initial begin
      set_note(0, 0, 0, 0, 0);
      do_reset();

      // Attack, decay, sustain hold, release to done.
      set_note(440, 64, 100, 80, 30);
      gate = 1'b1;
      cyc();
      chk("start_active", act, 1);
      chk("start_freq", ofreq, 440);
      chk("start_amp", amp, 0);
      run(PRE); chk("atk64", amp, 64);
      run(PRE); chk("atk128", amp, 128);
      run(PRE); chk("atk192", amp, 192);
      run(PRE); chk("atk255", amp, 255);
      run(PRE); chk("dec155", amp, 155);
      run(PRE); chk("dec80", amp, 80);
      set_note(1234, 7, 7, 7, 7);
      run(1000); chk("sus_hold", amp, 80);
      gate = 1'b0;
      cyc(); chk("rel_entry", amp, 80);
      begin
         int last;
         bit got_done;
         int seen[$];
         int exp_rel[3];
         exp_rel = '{50, 20, 0};
         last = 80; got_done = 0;
         for (int i = 0; i < 2000 && !got_done; i++) begin
            cyc();
            if (int'(amp) != last) begin seen.push_back(int'(amp)); last = int'(amp); end
            if (done) got_done = 1;
         end
         chk("rel_done_seen", got_done, 1);
`ifndef ENVELOPE_EXP_RELEASE_EN
         chk("rel_steps", seen.size(), 3);
         for (int i = 0; i < 3 && i < seen.size(); i++) chk("rel_val", seen[i], exp_rel[i]);
`endif
      end
      cyc();
      chk("done_one_cycle", done, 0);
      chk("idle_active", act, 0);
      chk("idle_freq", ofreq, 440);

      // Retrigger during release keeps the level and updates the frequency.
      set_note(440, 0, 0, 150, 30);
      gate = 1'b1;
      run(2 * PRE + 1);
      chk("sus150", amp, 150);
      gate = 1'b0;
      begin
         bit moved;
         moved = 0;
         for (int i = 0; i < 100 && !moved; i++) begin
            cyc();
            if (amp != 8'd150) moved = 1;
         end
         chk("rel_moved", moved, 1);
      end
      set_note(880, 16, 0, 100, 30);
      gate = 1'b1;
      cyc();
      chk("retrig_freq", ofreq, 880);
      chk("retrig_active", act, 1);
      chk("retrig_done", done, 0);
`ifdef ENVELOPE_EXP_RELEASE_EN
      chk("retrig_level", amp, 131);
`else
      chk("retrig_level", amp, 120);
`endif
      run(PRE); 
`ifdef ENVELOPE_EXP_RELEASE_EN
      chk("retrig_atk", amp, 147);
`else
      chk("retrig_atk", amp, 136);
`endif
      run(200);

      // Zero steps mean instant transitions.
      do_reset();
      set_note(300, 0, 0, 200, 0);
      gate = 1'b1;
      cyc();
      run(PRE); chk("zero_atk", amp, 255);
      run(PRE); chk("zero_dec", amp, 200);

      // Asynchronous reset in the middle of a note.
      do_reset();
      set_note(1000, 0, 85, 0, 10);
      gate = 1'b1;
      cyc();
      run(2 * PRE); chk("pre_rst", amp, 170);
      #2 rst_n = 1'b0;
      #1;
      chk("async_amp", amp, 0);
      chk("async_freq", ofreq, 0);
      chk("async_active", act, 0);
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      cyc();
      chk("post_rst_start", act, 1);
      run(3 * PRE);

`ifdef ENVELOPE_EXP_RELEASE_EN
      // Exponential release from full scale.
      do_reset();
      set_note(500, 0, 50, 10, 0);
      gate = 1'b1;
      cyc();
      run(PRE); chk("exp_peak", amp, 255);
      gate = 1'b0;
      cyc();
      begin
         int last;
         int seen[$];
         last = 255;
         for (int i = 0; i < 200 && seen.size() < 2; i++) begin
            cyc();
            if (int'(amp) != last) begin seen.push_back(int'(amp)); last = int'(amp); end
         end
         chk("exp_steps", seen.size(), 2);
         if (seen.size() >= 2) begin
            chk("exp_223", seen[0], 223);
            chk("exp_195", seen[1], 195);
         end
      end
`endif

      // Random notes with parameters changing every cycle (only start latches).
      do_reset();
      for (int n = 0; n < 40; n++) begin
         int hi, lo;
         hi = $urandom_range(1, 600);
         lo = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : $urandom_range(1, 900);
         gate = 1'b1;
         for (int i = 0; i < hi; i++) begin
            set_note($urandom_range(100, 8000),
                     ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 255),
                     ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 255),
                     ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(0, 255),
                     ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 60));
            cyc();
         end
         gate = 1'b0;
         run(lo);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
